// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : MEM-stage data-memory req/ack sequencer with pipeline stall,
//            MEM/WB bubble control and captured load data. Optional request
//            timeout (ERR state) is enabled by defining DMEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memreadM,
   input  logic        memwriteM,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] readdataM,
   output logic        err
);

   generate
      if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
         $error("dmem_access_ctrl: WAIT_MAX must be in 1..255");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
`ifdef DMEM_TIMEOUT_EN
      ,
      ST_ERR  = 2'd3
`endif
   } state_t;

   state_t      r_state;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_readdata;
   logic        r_err;

`ifdef DMEM_TIMEOUT_EN
   localparam int c_cnt_w = $clog2(WAIT_MAX + 1);
   localparam logic [c_cnt_w-1:0] c_wait_max  = c_cnt_w'(WAIT_MAX);
   localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(WAIT_MAX - 1);
   logic [c_cnt_w-1:0] r_wait_cnt;
`endif

   logic w_access;
   logic w_aligned;
   logic w_is_load;
   logic w_stall;

   assign w_access  = memreadM | memwriteM;
   assign w_aligned = (aluoutM[1:0] == 2'b00);
   // a simultaneous read+write is handled as a store
   assign w_is_load = memreadM & ~memwriteM;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_readdata  <= '0;
         r_err       <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         r_wait_cnt  <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_access) begin
                  if (w_aligned) begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= memwriteM;
                     r_mem_addr  <= aluoutM;
                     r_mem_wdata <= writedataM;
                     r_state     <= ST_REQ;
`ifdef DMEM_TIMEOUT_EN
                     r_wait_cnt  <= '0;
`endif
                  end else begin
                     r_err <= 1'b1;
                     if (w_is_load) begin
                        r_readdata <= '0;
                     end
                  end
               end
            end
            ST_REQ: begin
`ifdef DMEM_TIMEOUT_EN
               if (r_wait_cnt != c_wait_max) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
`endif
               // an ack in the same cycle as the last allowed wait still wins
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  if (!r_mem_we) begin
                     r_readdata <= mem_rdata;
                  end
                  r_state <= ST_DONE;
               end
`ifdef DMEM_TIMEOUT_EN
               else if (r_wait_cnt == c_wait_last) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_ERR;
               end
`endif
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
`ifdef DMEM_TIMEOUT_EN
            ST_ERR: begin
               r_readdata <= '0;
               r_err      <= 1'b1;
               r_state    <= ST_DONE;
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // IDLE must stall in the same cycle it accepts an access
   assign w_stall = rst_n & (((r_state == ST_IDLE) & w_access & w_aligned)
                             | (r_state == ST_REQ)
`ifdef DMEM_TIMEOUT_EN
                             | (r_state == ST_ERR)
`endif
                            );

   assign stall     = w_stall;
   assign wb_valid  = ~w_stall;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign readdataM = r_readdata;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Brief    : Self-checking bench for dmem_access_ctrl (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

`ifdef DMEM_TIMEOUT_EN
   localparam int MAXD = 3;
`else
   localparam int MAXD = 6;
`endif

   logic        clk;
   logic        rst_n;
   logic        memreadM;
   logic        memwriteM;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        wb_valid;
   logic [31:0] readdataM;
   logic        err;

   int          n_checks;
   int          n_fail;
   logic [31:0] exp_rd;
   logic        exp_err;

   dmem_access_ctrl #(.WAIT_MAX(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .memreadM   (memreadM),
      .memwriteM  (memwriteM),
      .aluoutM    (aluoutM),
      .writedataM (writedataM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .stall      (stall),
      .wb_valid   (wb_valid),
      .readdataM  (readdataM),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // one cycle with no memory instruction; optionally a stray ack that must be ignored
   task automatic idle(input logic poke_ack);
      @(negedge clk);
      memreadM   = 1'b0;
      memwriteM  = 1'b0;
      aluoutM    = $urandom;
      writedataM = $urandom;
      mem_ack    = poke_ack;
      mem_rdata  = $urandom;
      #2;
      chk1("idle_stall", stall, 1'b0);
      chk1("idle_wbv", wb_valid, 1'b1);
      chk1("idle_req", mem_req, 1'b0);
      chk("idle_rdata", readdataM, exp_rd);
      chk1("idle_err", err, exp_err);
   endtask

   // one MEM-stage instruction; ack arrives d cycles after mem_req rises
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int d, input logic [31:0] rdv);
      logic ok;
      logic is_load;
      ok      = (addr[1:0] == 2'b00);
      is_load = rd & ~wr;
      @(negedge clk);
      memreadM   = rd;
      memwriteM  = wr;
      aluoutM    = addr;
      writedataM = wd;
      mem_ack    = 1'b0;
      mem_rdata  = $urandom;
      #2;
      chk1("acc_idle_stall", stall, ok);
      chk1("acc_idle_wbv", wb_valid, ~ok);
      chk1("acc_idle_req", mem_req, 1'b0);
      chk("acc_idle_rdata", readdataM, exp_rd);
      chk1("acc_idle_err", err, exp_err);
      if (!ok) begin
         exp_err = 1'b1;
         if (is_load) exp_rd = 32'h0;
         return;
      end
      for (int k = 0; k <= d; k++) begin
         @(negedge clk);
         mem_ack   = (k == d);
         mem_rdata = (k == d) ? rdv : $urandom;
         #2;
         chk1("req_req", mem_req, 1'b1);
         chk1("req_we", mem_we, wr);
         chk("req_addr", mem_addr, addr);
         chk("req_wdata", mem_wdata, wd);
         chk1("req_stall", stall, 1'b1);
         chk1("req_wbv", wb_valid, 1'b0);
         chk("req_rdata", readdataM, exp_rd);
      end
      if (is_load) exp_rd = rdv;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      #2;
      chk1("done_req", mem_req, 1'b0);
      chk1("done_stall", stall, 1'b0);
      chk1("done_wbv", wb_valid, 1'b1);
      chk("done_rdata", readdataM, exp_rd);
      chk1("done_err", err, exp_err);
   endtask

   initial begin
      logic        rd;
      logic        wr;
      logic [31:0] a;
      n_checks   = 0;
      n_fail     = 0;
      exp_rd     = 32'h0;
      exp_err    = 1'b0;
      rst_n      = 1'b0;
      memreadM   = 1'b0;
      memwriteM  = 1'b0;
      aluoutM    = 32'h0;
      writedataM = 32'h0;
      mem_rdata  = 32'h0;
      mem_ack    = 1'b0;
      #1;
      chk1("rst_req", mem_req, 1'b0);
      chk1("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", readdataM, 32'h0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_wbv", wb_valid, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      idle(1'b0);
      access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hCAFEF00D);
      access(1'b0, 1'b1, 32'h20, 32'h12345678, 3, 32'h0);
      idle(1'b1);
      access(1'b1, 1'b0, 32'h0, 32'h0, 0, 32'h11111111);
      access(1'b1, 1'b0, 32'h4, 32'h0, 0, 32'h22222222);
      access(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1, 32'hFFFFFFFF);
      access(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h0);
      idle(1'b0);
      access(1'b1, 1'b0, 32'h30, 32'h0, 2, 32'h0BADC0DE);

`ifdef DMEM_TIMEOUT_EN
      @(negedge clk);
      memreadM  = 1'b1;
      memwriteM = 1'b0;
      aluoutM   = 32'h80;
      mem_ack   = 1'b0;
      #2;
      chk1("to_idle_stall", stall, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #2;
         chk1("to_req_req", mem_req, 1'b1);
         chk1("to_req_stall", stall, 1'b1);
      end
      @(negedge clk);
      #2;
      chk1("to_err_req", mem_req, 1'b0);
      chk1("to_err_stall", stall, 1'b1);
      chk1("to_err_wbv", wb_valid, 1'b0);
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #2;
      exp_err = 1'b1;
      exp_rd  = 32'h0;
      chk1("to_done_stall", stall, 1'b0);
      chk1("to_done_wbv", wb_valid, 1'b1);
      chk1("to_done_err", err, 1'b1);
      chk("to_done_rdata", readdataM, 32'h0);
      idle(1'b0);
`endif

      // asynchronous reset in the middle of a request
      @(negedge clk);
      memreadM  = 1'b1;
      memwriteM = 1'b0;
      aluoutM   = 32'h40;
      mem_ack   = 1'b0;
      @(negedge clk);
      #2;
      chk1("mid_req_up", mem_req, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_req", mem_req, 1'b0);
      chk1("mid_rst_stall", stall, 1'b0);
      chk1("mid_rst_wbv", wb_valid, 1'b1);
      chk1("mid_rst_err", err, 1'b0);
      chk("mid_rst_rdata", readdataM, 32'h0);
      chk("mid_rst_addr", mem_addr, 32'h0);
      @(negedge clk);
      memreadM = 1'b0;
      rst_n    = 1'b1;
      exp_err  = 1'b0;
      exp_rd   = 32'h0;
      idle(1'b0);
      access(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'h600DF00D);

      for (int t = 0; t < 30; t++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = $urandom;
         if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         if (!rd && !wr) idle(1'($urandom_range(0, 1)));
         else access(rd, wr, a, $urandom, int'($urandom_range(0, MAXD)), $urandom);
         if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
      end
      idle(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
